// File: rtl/ip_pkg.sv
// Shared constants and FSM encoding for the line feeder that primes ip_top's line buffers.
package ip_pkg;

    localparam int IMG_W_DEF       = 512;
    localparam int IMG_H_DEF       = 512;
    localparam int PRIME_LINES_DEF = 4;
    localparam int FLUSH_LINES_DEF = 2;
    localparam int DW_DEF          = 8;
    localparam int CREDIT_W        = 3;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PRIME      = 3'd1,
        S_WAIT_INTR  = 3'd2,
        S_LINE       = 3'd3,
        S_FLUSH_WAIT = 3'd4,
        S_FLUSH      = 3'd5,
        S_DONE       = 3'd6
    } state_t;

endpackage

// File: rtl/ip_line_feeder_if.sv
// Pixel stream bundle: source valid/ready input side and the unthrottled output towards ip_top.
interface ip_line_feeder_if
    import ip_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          s_data_valid;
    logic [DW-1:0] s_data;
    logic          s_data_ready;
    logic          o_data_valid;
    logic [DW-1:0] o_data;

    modport master (
        output s_data_valid, s_data,
        input  s_data_ready, o_data_valid, o_data
    );

    modport slave (
        input  s_data_valid, s_data,
        output s_data_ready, o_data_valid, o_data
    );
endinterface

// File: rtl/ip_intr_credit.sv
// Rising-edge detector on ip_top's intr plus a saturating line credit counter.
module ip_intr_credit
    import ip_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic i_intr,
    input  logic consume,
    output logic credit_avail,
    output logic overflow,
    output logic stray
);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    logic                intr_q;
    logic                intr_prev;
    logic                rise;
    logic [CREDIT_W-1:0] credit;

    always_ff @(posedge clk) begin
        if (rst) begin
            intr_q    <= 1'b0;
            intr_prev <= 1'b0;
        end else begin
            intr_q    <= i_intr;
            intr_prev <= intr_q;
        end
    end

    assign rise = intr_q & ~intr_prev;

    // Credits only live while a frame is in flight; IDLE flushes leftovers.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            credit <= '0;
        end else if (rise && consume) begin
            credit <= credit;
        end else if (rise && credit != CREDIT_MAX) begin
            credit <= credit + CREDIT_W'(1);
        end else if (consume) begin
            credit <= credit - CREDIT_W'(1);
        end
    end

    assign credit_avail = credit != '0;
    assign overflow     = rise & en & (credit == CREDIT_MAX);
    assign stray        = rise & ~en;

endmodule

// File: rtl/ip_line_feeder.sv
// Feeds ip_top: primes PRIME_LINES lines, then one line per intr credit, then zero flush lines.
// Optional sticky credit error output enabled by IP_LINE_FEEDER_ERR_EN.
module ip_line_feeder
    import ip_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEF,
    parameter int IMG_H       = IMG_H_DEF,
    parameter int PRIME_LINES = PRIME_LINES_DEF,
    parameter int FLUSH_LINES = FLUSH_LINES_DEF
) (
    input  logic axi_clk,
    input  logic axi_rst,
    input  logic start,
    input  logic i_intr,
    ip_line_feeder_if.slave bus,
    output logic busy,
    output logic done
`ifdef IP_LINE_FEEDER_ERR_EN
    ,
    output logic o_err
`endif
);
    localparam int PIX_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int LINE_W  = $clog2(IMG_H + 1);
    localparam int FLUSH_W = $clog2(FLUSH_LINES + 1);

    state_t             state;
    state_t             state_nxt;
    logic [PIX_W-1:0]   pix_cnt;
    logic [LINE_W-1:0]  line_cnt;
    logic [LINE_W-1:0]  line_inc;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [FLUSH_W-1:0] flush_inc;
    logic               beat;
    logic               emit_flush;
    logic               pix_last;
    logic               consume;
    logic               credit_avail;
    logic               overflow;
    logic               stray;

    assign bus.s_data_ready = (state == S_PRIME) || (state == S_LINE);
    assign beat             = bus.s_data_valid & bus.s_data_ready;
    assign emit_flush       = state == S_FLUSH;
    assign pix_last         = pix_cnt == PIX_W'(IMG_W - 1);
    assign line_inc         = line_cnt + LINE_W'(1);
    assign flush_inc        = flush_cnt + FLUSH_W'(1);
    assign busy             = state != S_IDLE;
    assign done             = state == S_DONE;

    ip_intr_credit u_credit (
        .clk          (axi_clk),
        .rst          (axi_rst),
        .en           (busy),
        .i_intr       (i_intr),
        .consume      (consume),
        .credit_avail (credit_avail),
        .overflow     (overflow),
        .stray        (stray)
    );

    always_comb begin
        state_nxt = state;
        consume   = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_PRIME;
            S_PRIME, S_LINE: begin
                if (beat && pix_last) begin
                    if (line_inc == LINE_W'(IMG_H))
                        state_nxt = S_FLUSH_WAIT;
                    else if (state == S_LINE || line_inc == LINE_W'(PRIME_LINES))
                        state_nxt = S_WAIT_INTR;
                end
            end
            S_WAIT_INTR: begin
                if (credit_avail) begin
                    consume   = 1'b1;
                    state_nxt = S_LINE;
                end
            end
            S_FLUSH_WAIT: begin
                if (credit_avail) begin
                    consume   = 1'b1;
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (pix_last)
                    state_nxt = (flush_inc == FLUSH_W'(FLUSH_LINES)) ? S_DONE : S_FLUSH_WAIT;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state            <= S_IDLE;
            pix_cnt          <= '0;
            line_cnt         <= '0;
            flush_cnt        <= '0;
            bus.o_data_valid <= 1'b0;
            bus.o_data       <= '0;
        end else begin
            state            <= state_nxt;
            bus.o_data_valid <= beat | emit_flush;
            bus.o_data       <= beat ? bus.s_data : '0;
            if (state == S_IDLE) begin
                pix_cnt   <= '0;
                line_cnt  <= '0;
                flush_cnt <= '0;
            end else if (beat || emit_flush) begin
                // One pixel counter serves both source lines and flush lines.
                pix_cnt <= pix_last ? '0 : pix_cnt + PIX_W'(1);
                if (pix_last && beat)       line_cnt  <= line_inc;
                if (pix_last && emit_flush) flush_cnt <= flush_inc;
            end
        end
    end

`ifdef IP_LINE_FEEDER_ERR_EN
    always_ff @(posedge axi_clk) begin
        if (axi_rst)                o_err <= 1'b0;
        else if (overflow || stray) o_err <= 1'b1;
    end
`else
    logic unused_err;
    assign unused_err = overflow | stray;
`endif

endmodule

// File: tb/tb_ip_line_feeder.sv
// Self-checking bench for ip_line_feeder: table of frame scenarios plus reset/error sequences.
`timescale 1ns/1ps
module tb_ip_line_feeder;
    import ip_pkg::*;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int PL   = 4;
    localparam int FL   = 2;
    localparam int NPIX = W * H;
    localparam int NOUT = W * (H + FL);

    localparam int M_LAZY  = 0;
    localparam int M_EARLY = 1;
    localparam int M_SIM   = 2;
    localparam int M_ERR   = 3;

    typedef struct {
        bit gaps;
        int mode;
        int exp_beats;
        int span;
        int gap32;
        int gap40;
    } frame_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic intr = 1'b0;
    logic busy;
    logic done;
`ifdef IP_LINE_FEEDER_ERR_EN
    logic o_err;
`endif

    ip_line_feeder_if #(.DW(8)) bus ();

    ip_line_feeder #(.IMG_W(W), .IMG_H(H), .PRIME_LINES(PL), .FLUSH_LINES(FL)) dut (
        .axi_clk (clk),
        .axi_rst (rst),
        .start   (start),
        .i_intr  (intr),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
`ifdef IP_LINE_FEEDER_ERR_EN
        ,
        .o_err   (o_err)
`endif
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         out_beats = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         presented = 0;
    int         beat_cyc[128];
    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];
    frame_vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pix(input int f, input int i);
        return 8'(i + 1 + 50 * f);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mon_en && bus.o_data_valid) begin
            check("beat_data", int'(bus.o_data),
                  exp_q.size() > 0 ? int'(exp_q.pop_front()) : -1);
            if (out_beats < 128) beat_cyc[out_beats] = cyc;
            out_beats++;
        end
    end

    task automatic pulse();
        intr = 1'b1;
        @(posedge clk); #1;
        intr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_beats(input int n, input string name);
        int t = 0;
        while (out_beats < n && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, int'(out_beats >= n), 1);
    endtask

    task automatic drive_src(input bit gaps, input int f);
        int idx = 0;
        int c = 0;
        int t = 0;
        bit v;
        bit acc;
        bit pushed = 1'b0;
        while (idx < NPIX && t < 5000) begin
            v = gaps ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            bus.s_data_valid = v;
            bus.s_data       = pix(f, idx);
            if (v && !pushed) begin
                exp_q.push_back(pix(f, idx));
                pushed = 1'b1;
                presented++;
                if (idx == NPIX - 1) repeat (W * FL) exp_q.push_back(8'h00);
            end
            @(negedge clk);
            acc = v && bus.s_data_ready;
            if (gaps && !v && (idx % W) != 0) check("ready_in_gap", int'(bus.s_data_ready), 1);
            @(posedge clk); #1;
            c++;
            t++;
            if (acc) begin
                idx++;
                pushed = 1'b0;
            end
        end
        bus.s_data_valid = 1'b0;
        check("src_all_taken", idx, NPIX);
    endtask

    task automatic intr_seq(input int mode);
        int t = 0;
        case (mode)
            M_LAZY: begin
                for (int k = 0; k < 4; k++) begin
                    wait_beats(32 + 8 * k, "lazy_wait");
                    repeat (5) @(posedge clk);
                    #1;
                    pulse();
                end
            end
            M_EARLY: begin
                repeat (3) @(posedge clk);
                #1;
                pulse();
                pulse();
                wait_beats(48, "early_wait48");
                repeat (20) @(posedge clk);
                #1;
                check("stall_beats", out_beats, 48);
                check("stall_busy", int'(busy), 1);
                check("stall_state", int'(dut.state), int'(S_FLUSH_WAIT));
                pulse();
                wait_beats(56, "early_wait56");
                repeat (5) @(posedge clk);
                #1;
                pulse();
            end
            M_SIM: begin
                repeat (3) @(posedge clk);
                #1;
                pulse();
                while (presented < 32 && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                check("sim_presented", int'(presented >= 32), 1);
                intr = 1'b1;
                @(posedge clk); #1;
                intr = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("sim_credit", int'(dut.u_credit.credit), 1);
                check("sim_state", int'(dut.state), int'(S_LINE));
                wait_beats(48, "sim_wait48");
                repeat (5) @(posedge clk);
                #1;
                pulse();
                wait_beats(56, "sim_wait56");
                repeat (5) @(posedge clk);
                #1;
                pulse();
            end
`ifdef IP_LINE_FEEDER_ERR_EN
            M_ERR: begin
                repeat (3) @(posedge clk);
                #1;
                for (int k = 0; k < 7; k++) pulse();
                @(negedge clk);
                check("err_credit7", int'(dut.u_credit.credit), 7);
                check("err_clear_at7", int'(o_err), 0);
                pulse();
                @(negedge clk);
                check("err_set_8th", int'(o_err), 1);
                check("err_sat7", int'(dut.u_credit.credit), 7);
            end
`endif
            default: ;
        endcase
    endtask

    task automatic run_frame(input frame_vec_t v, input int f);
        int t = 0;
        exp_q.delete();
        out_beats = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        presented = 0;
        check("idle_before", int'(busy), 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fork
            drive_src(v.gaps, f);
            intr_seq(v.mode);
        join
        while (done_cnt == 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("frame_beats", out_beats, v.exp_beats);
        check("done_once", done_cnt, 1);
        check("queue_empty", exp_q.size(), 0);
        check("busy_end", int'(busy), 0);
        check("done_after_last", done_cyc, beat_cyc[NOUT-1]);
        if (v.span != 0)  check("prime_span", beat_cyc[31] - beat_cyc[0], v.span);
        if (v.gap32 != 0) check("gap32", beat_cyc[32] - beat_cyc[31], v.gap32);
        if (v.gap40 != 0) check("gap40", beat_cyc[40] - beat_cyc[39], v.gap40);
`ifdef IP_LINE_FEEDER_ERR_EN
        if (v.mode == M_ERR) check("err_sticky", int'(o_err), 1);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{gaps: 1'b0, mode: M_LAZY,  exp_beats: NOUT, span: 31, gap32: 0, gap40: 0});
        vecs.push_back('{gaps: 1'b1, mode: M_LAZY,  exp_beats: NOUT, span: 0,  gap32: 0, gap40: 0});
        vecs.push_back('{gaps: 1'b0, mode: M_EARLY, exp_beats: NOUT, span: 31, gap32: 2, gap40: 2});
        vecs.push_back('{gaps: 1'b0, mode: M_SIM,   exp_beats: NOUT, span: 31, gap32: 2, gap40: 2});
`ifdef IP_LINE_FEEDER_ERR_EN
        vecs.push_back('{gaps: 1'b0, mode: M_ERR,   exp_beats: NOUT, span: 31, gap32: 2, gap40: 2});
`endif
        bus.s_data_valid = 1'b0;
        bus.s_data       = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", int'(bus.o_data_valid), 0);
        check("rst_data", int'(bus.o_data), 0);
        check("rst_ready", int'(bus.s_data_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
`ifdef IP_LINE_FEEDER_ERR_EN
        check("rst_err", int'(o_err), 0);
`endif

        // Reset mid-LINE aborts the frame.
        @(posedge clk); #1;
        start = 1'b1;
        bus.s_data_valid = 1'b1;
        bus.s_data = 8'hA5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pulse();
        repeat (33) @(posedge clk);
        #1;
        check("midline_state", int'(dut.state), int'(S_LINE));
        done_cnt = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.s_data_valid = 1'b0;
        @(negedge clk);
        check("abort_valid", int'(bus.o_data_valid), 0);
        check("abort_data", int'(bus.o_data), 0);
        check("abort_ready", int'(bus.s_data_ready), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_state", int'(dut.state), int'(S_IDLE));
        check("abort_credit", int'(dut.u_credit.credit), 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);

        mon_en = 1'b1;
        foreach (vecs[i]) begin
            run_frame(vecs[i], i);
            repeat (3) @(posedge clk);
            #1;
        end

`ifdef IP_LINE_FEEDER_ERR_EN
        // Stray intr edge while IDLE.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_err_clear", int'(o_err), 0);
        pulse();
        @(negedge clk);
        check("idle_err_set", int'(o_err), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
